// File: rtl/i2s_sample_bridge_if.sv
// i2s_sample_bridge_if: codec serial pins plus the engine sample handshake
interface i2s_sample_bridge_if #(
  parameter int data_width = 16
);
  logic                  i2s_bclk;
  logic                  i2s_lrclk;
  logic                  i2s_sdin;
  logic                  i2s_sdout;
  logic [data_width-1:0] in_sample;
  logic                  sample_valid;
  logic [data_width-1:0] out_sample;
  logic                  engine_ready;
  logic [7:0]            late_count;
  modport master (
    output i2s_bclk, i2s_lrclk, i2s_sdout, in_sample, sample_valid, late_count,
    input  i2s_sdin, out_sample, engine_ready
  );
  modport slave (
    input  i2s_bclk, i2s_lrclk, i2s_sdout, in_sample, sample_valid, late_count,
    output i2s_sdin, out_sample, engine_ready
  );
endinterface

// File: rtl/i2s_sample_bridge.sv
// i2s_sample_bridge: I2S master that feeds left ADC samples to the engine and plays its results on both DAC slots
module i2s_sample_bridge #(
  parameter int data_width = 16,
  parameter int slot_width = 32,
  parameter int bclk_div   = 4
) (
  input logic                clk,
  input logic                reset,
  i2s_sample_bridge_if.master bus
);
  localparam int D  = data_width;
  localparam int S  = slot_width;
  localparam int F  = 2 * slot_width;
  localparam int dw = $clog2(bclk_div);
  localparam int pw = $clog2(F);
  localparam logic [dw-1:0] div_last = dw'(bclk_div - 1);
  localparam logic [pw-1:0] p_last   = pw'(F - 1);
  logic [dw-1:0] div_ctr;
  logic [pw-1:0] p, p_nxt;
  logic          bclk, lrclk, sdout, pend, sample_valid, prev_ready, result_fresh;
  logic          tick, rise, fall, frame_start, right_start, tx_act, capture;
  logic [D-1:0]  rx_shift, tx_shift, tx_hold, tx_copy, tx_src, in_sample;
  logic [7:0]    late;
  always_comb begin
    tick        = div_ctr == div_last;
    rise        = tick && !bclk;
    fall        = tick && bclk;
    p_nxt       = (p == p_last) ? '0 : p + 1'b1;
    frame_start = fall && p_nxt == '0;
    right_start = fall && p_nxt == pw'(S);
    tx_act      = p_nxt < pw'(D) || (p_nxt >= pw'(S) && p_nxt < pw'(S + D));
    tx_src      = frame_start ? tx_hold : right_start ? tx_copy : tx_shift;
    capture     = bus.engine_ready && !prev_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_ctr      <= '0;
      bclk         <= 1'b0;
      lrclk        <= 1'b1;
      sdout        <= 1'b0;
      p            <= p_last;
      rx_shift     <= '0;
      tx_shift     <= '0;
      tx_hold      <= '0;
      tx_copy      <= '0;
      in_sample    <= '0;
      pend         <= 1'b0;
      sample_valid <= 1'b0;
      prev_ready   <= 1'b0;
      result_fresh <= 1'b0;
      late         <= '0;
    end else begin
      div_ctr      <= tick ? '0 : div_ctr + 1'b1;
      bclk         <= tick ? !bclk : bclk;
      prev_ready   <= bus.engine_ready;
      pend         <= rise && p == pw'(D - 1);
      sample_valid <= pend;
      if (pend) in_sample <= rx_shift;
      if (rise && p < pw'(D)) rx_shift <= {rx_shift[D-2:0], bus.i2s_sdin};
      // tx_shift holds the bits still to be sent; the MSB goes straight to sdout
      if (fall) begin
        p     <= p_nxt;
        lrclk <= p_nxt >= pw'(S - 1) && p_nxt <= pw'(F - 2);
        sdout <= tx_act && tx_src[D-1];
        if (tx_act) tx_shift <= tx_src << 1;
      end
      if (frame_start) begin
        tx_copy <= tx_hold;
        if (!result_fresh && late != 8'hFF) late <= late + 8'd1;
      end
      result_fresh <= capture ? 1'b1 : frame_start ? 1'b0 : result_fresh;
      if (capture) tx_hold <= bus.out_sample;
    end
  end
  assign bus.i2s_bclk     = bclk;
  assign bus.i2s_lrclk    = lrclk;
  assign bus.i2s_sdout    = sdout;
  assign bus.in_sample    = in_sample;
  assign bus.sample_valid = sample_valid;
  assign bus.late_count   = late;
endmodule

// File: tb/tb_i2s_sample_bridge.sv
// tb_i2s_sample_bridge: codec and engine models around the bridge, with a scoreboard of expected samples
module tb_i2s_sample_bridge;
  localparam int D  = 16;
  localparam int S  = 32;
  localparam int BD = 2;
  localparam int F  = 2 * S;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
    logic [15:0] play;
    logic [1:0]  mode;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  i2s_sample_bridge_if #(.data_width(D)) bus ();
  i2s_sample_bridge #(.data_width(D), .slot_width(S), .bclk_div(BD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  vec_t tbl [3];
  int cur = 0;
  logic [15:0] sb [$];
  int tb_p, cnt, pulses, frames, eng_t, eng_h, model_late;
  logic [31:0] w;
  logic [15:0] model_hold, model_play, fl, fr, fplay, eng_v, want;
  logic [1:0] fmode;
  logic model_fresh, prev_bclk, prev_sv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic wait_frames(input int n);
    int tgt;
    tgt = frames + n;
    for (int i = 0; i < n * F * 2 * BD + 200 && frames < tgt; i++) @(posedge clk);
    if (frames < tgt) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got %0d frames want %0d", frames, tgt);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bclk"}, bus.i2s_bclk, 0);
    check({tag, "_lrclk"}, bus.i2s_lrclk, 1);
    check({tag, "_sdout"}, bus.i2s_sdout, 0);
    check({tag, "_in_sample"}, bus.in_sample, 0);
    check({tag, "_sample_valid"}, bus.sample_valid, 0);
    check({tag, "_late_count"}, bus.late_count, 0);
  endtask

  // codec, engine and monitor: everything reacts on the negative clock edge
  initial begin
    fl = '0;
    fr = '0;
    fplay = '0;
    fmode = '0;
    eng_v = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        tb_p = F - 1;
        cnt = 0;
        pulses = 0;
        frames = 0;
        eng_t = 0;
        eng_h = 0;
        model_hold = '0;
        model_play = '0;
        model_fresh = 1'b0;
        model_late = 0;
        prev_bclk = 1'b0;
        prev_sv = 1'b0;
        w = '0;
        bus.i2s_sdin = 1'b0;
        bus.engine_ready = 1'b0;
        bus.out_sample = '0;
      end else begin
        if (bus.sample_valid) begin
          pulses++;
          check("sv_width", prev_sv, 0);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sv_unexpected: got pulse with in_sample %h want no pulse", bus.in_sample);
          end else begin
            want = sb.pop_front();
            check("in_sample", bus.in_sample, want);
            if (fmode != 0) begin
              eng_t = 20;
              eng_v = (fmode == 2'd1) ? ~want : want;
            end
          end
        end
        prev_sv = bus.sample_valid;
        if (!bus.i2s_bclk && prev_bclk) begin
          tb_p = (tb_p == F - 1) ? 0 : tb_p + 1;
          if (tb_p == 0) begin
            if (cnt == S) check("dac_right", w, {model_play, 16'h0000});
            if (frames > 0) check("pulses_per_frame", pulses, 1);
            pulses = 0;
            frames++;
            if (!model_fresh && model_late < 255) model_late++;
            model_fresh = 1'b0;
            check("late_count", bus.late_count, model_late);
            model_play = model_hold;
            cnt = 0;
            fl = tbl[cur].left;
            fr = tbl[cur].right;
            fplay = tbl[cur].play;
            fmode = tbl[cur].mode;
            sb.push_back(fl);
          end else if (tb_p == S) begin
            if (cnt == S) check("dac_left", w, {model_play, 16'h0000});
            cnt = 0;
          end
          check("lrclk_vs_p", bus.i2s_lrclk, tb_p >= S - 1 && tb_p <= F - 2);
          bus.i2s_sdin = (tb_p < D) ? fl[D-1-tb_p] : (tb_p >= S && tb_p < S + D) ? fr[S+D-1-tb_p] : 1'b0;
        end
        if (bus.i2s_bclk && !prev_bclk) begin
          w = {w[30:0], bus.i2s_sdout};
          cnt++;
        end
        prev_bclk = bus.i2s_bclk;
        if (eng_t > 0) begin
          eng_t--;
          if (eng_t == 0) begin
            bus.out_sample = eng_v;
            bus.engine_ready = 1'b1;
            model_hold = fplay;
            model_fresh = 1'b1;
            eng_h = 4;
          end
        end else if (eng_h > 0) begin
          eng_h--;
          if (eng_h == 0) bus.engine_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    int rise_at, fall_at;
    tbl[0] = '{left: 16'hA5C3, right: 16'hFFFF, play: 16'h5A3C, mode: 2'd1};
    tbl[1] = '{left: 16'h8000, right: 16'hFFFF, play: 16'h8000, mode: 2'd2};
    tbl[2] = '{left: 16'h1234, right: 16'h0F0F, play: 16'h8000, mode: 2'd0};
    cur = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    rise_at = 0;
    fall_at = 0;
    for (int i = 1; i <= 4 * BD; i++) begin
      @(posedge clk);
      #1;
      if (bus.i2s_bclk && rise_at == 0) rise_at = i;
      if (!bus.i2s_lrclk && fall_at == 0) fall_at = i;
    end
    check("first_bclk_rise", rise_at, BD);
    check("first_lrclk_fall", fall_at, 2 * BD);
    wait_frames(4);
    cur = 1;
    wait_frames(4);
    cur = 2;
    wait_frames(265);
    check("late_saturated", bus.late_count, 255);
    cur = 0;
    wait_frames(2);
    begin
      int i;
      for (i = 0; i < 4 * F * BD && tb_p != 8; i++) @(posedge clk);
      if (tb_p != 8) begin
        total++;
        bad++;
        $display("FAIL p8_timeout: got p=%0d want 8", tb_p);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    wait_frames(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
